hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage RISC-V core.
- Drives the write enable of the PC and the IF/ID register, the flush of IF/ID, bubble injection into the ID/EX register (forces all ID/EX control outputs to 0), and a global hold for the ID/EX, EX/MEM and MEM/WB registers.
- Resolves three events:
  - load-use hazards: one bubble;
  - taken branches resolved in EX: flush plus redirect wait;
  - multi-cycle data-memory stalls: full freeze, with watchdog.

---
 rtl/hazard_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for load-use bubbles, taken-branch redirect and data-memory freeze
module hazard_ctrl #(
  parameter int unsigned REDIRECT_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs1,
  input  logic             if_id_uses_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);
  typedef enum logic [1:0] {RUN = 2'd0, REDIRECT = 2'd1, MEM_WAIT = 2'd2} state_e;
  localparam logic [3:0] RC = 4'(REDIRECT_CYCLES);
  localparam logic [7:0] MT = 8'(MEM_TIMEOUT);
  state_e state_q, state_d;
  logic [3:0] redir_q, redir_d;
  logic [7:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic timeout_q;
  logic load_use, run_mode, pc_we, ifid_we, flush, bubble, hold, flush_evt;
  assign load_use = id_ex_memread && id_ex_rd != 5'd0 &&
                    ((if_id_uses_rs1 && if_id_rs1 == id_ex_rd) || (if_id_uses_rs2 && if_id_rs2 == id_ex_rd));
  // a released MEM_WAIT behaves exactly like RUN in the same cycle
  assign run_mode = state_q == RUN || (state_q != REDIRECT && !dmem_busy);
  always_comb begin
    pc_we = 1'b1;
    ifid_we = 1'b1;
    flush = 1'b0;
    bubble = 1'b0;
    hold = 1'b0;
    flush_evt = 1'b0;
    state_d = state_q;
    redir_d = redir_q;
    wait_d = wait_q;
    if (run_mode) begin
      state_d = RUN;
      wait_d = 8'd0;
      if (dmem_busy) begin
        hold = 1'b1;
        pc_we = 1'b0;
        ifid_we = 1'b0;
        state_d = MEM_WAIT;
        wait_d = 8'd1;
      end else if (ex_branch_taken) begin
        flush = 1'b1;
        bubble = 1'b1;
        flush_evt = 1'b1;
        state_d = RC != 4'd0 ? REDIRECT : RUN;
        redir_d = RC;
      end else if (load_use) begin
        pc_we = 1'b0;
        ifid_we = 1'b0;
        bubble = 1'b1;
      end
    end else if (state_q == REDIRECT) begin
      pc_we = 1'b0;
      flush = 1'b1;
      bubble = 1'b1;
      hold = dmem_busy;
      ifid_we = !dmem_busy;
      redir_d = dmem_busy ? redir_q : redir_q - 4'd1;
      state_d = !dmem_busy && redir_q <= 4'd1 ? RUN : REDIRECT;
    end else begin
      hold = 1'b1;
      pc_we = 1'b0;
      ifid_we = 1'b0;
      state_d = MEM_WAIT;
      wait_d = wait_q >= MT ? MT : wait_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      redir_q <= 4'd0;
      wait_q <= 8'd0;
      stall_q <= '0;
      flush_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      wait_q <= wait_d;
      if (!pc_we && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (flush_evt && flush_q != '1) flush_q <= flush_q + 1'b1;
      if (dmem_busy && state_q != REDIRECT && wait_d == MT) timeout_q <= 1'b1;
    end
  end
  assign pc_write_en = reset && pc_we;
  assign if_id_write_en = reset && ifid_we;
  assign if_id_flush = !reset || flush;
  assign id_ex_bubble = !reset || bubble;
  assign pipe_hold = reset && hold;
  assign state = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign mem_timeout = timeout_q;
endmodule
